// File: rtl/dz_pkg.sv
// dz_pkg: shared definitions for the LED dot-matrix row-scan controller.
//   row_w()      : width of a row index (clog2, minimum 1)
//   cnt_w()      : width of a 0..n-1 counter (clog2, minimum 1)
//   blink_ph_e   : blink phase encoding (visible / off)
package dz_pkg;

  typedef enum logic {
    PH_VISIBLE = 1'b0,
    PH_OFF     = 1'b1
  } blink_ph_e;

  function automatic int row_w(input int rows);
    return (rows > 1) ? $clog2(rows) : 1;
  endfunction

  function automatic int cnt_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/dz_scan_ctrl_if.sv
// dz_scan_ctrl_if: bundle between the game logic / pattern generator (master)
// and the row-scan controller (slave).
//   en, blink            : scan enable, blink mode enable
//   wr_en, wr_row,
//   wr_red, wr_green     : back-bank row write port
//   swap_req, swap_pend  : bank swap request / swap waiting for frame boundary
//   frame_start          : one-clk pulse when row 0 is first driven
//   row_n, col_r, col_g  : matrix pins (active-low rows, active-high columns)
interface dz_scan_ctrl_if #(
  parameter int ROWS = 8,
  parameter int COLS = 8
);
  import dz_pkg::*;

  localparam int RW = row_w(ROWS);

  logic            en;
  logic            wr_en;
  logic [RW-1:0]   wr_row;
  logic [COLS-1:0] wr_red;
  logic [COLS-1:0] wr_green;
  logic            swap_req;
  logic            swap_pend;
  logic            blink;
  logic            frame_start;
  logic [ROWS-1:0] row_n;
  logic [COLS-1:0] col_r;
  logic [COLS-1:0] col_g;

  modport master (
    output en, wr_en, wr_row, wr_red, wr_green, swap_req, blink,
    input  swap_pend, frame_start, row_n, col_r, col_g
  );

  modport slave (
    input  en, wr_en, wr_row, wr_red, wr_green, swap_req, blink,
    output swap_pend, frame_start, row_n, col_r, col_g
  );

endinterface

// File: rtl/dz_frame_buf.sv
// dz_frame_buf: double-buffered frame store, two banks of ROWS x {red, green}.
//   clk, rst             : clock, async active-high reset (clears both banks)
//   wr_en, wr_row,
//   wr_red, wr_green     : write into the back bank; out-of-range rows ignored
//   toggle               : swap front/back on this edge
//   rd_row               : front-bank row to read
//   rd_red, rd_green     : front-bank row contents (combinational)
module dz_frame_buf
  import dz_pkg::*;
#(
  parameter int ROWS = 8,
  parameter int COLS = 8,
  parameter int RW   = row_w(ROWS)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            wr_en,
  input  logic [RW-1:0]   wr_row,
  input  logic [COLS-1:0] wr_red,
  input  logic [COLS-1:0] wr_green,
  input  logic            toggle,
  input  logic [RW-1:0]   rd_row,
  output logic [COLS-1:0] rd_red,
  output logic [COLS-1:0] rd_green
);

  typedef struct packed {
    logic [COLS-1:0] red;
    logic [COLS-1:0] green;
  } pair_t;

  localparam logic [RW:0] ROWS_EXT = (RW + 1)'(ROWS);

  pair_t mem [2][ROWS];
  logic  front;
  logic  back;
  logic  wr_ok;

  assign back  = ~front;
  assign wr_ok = wr_en && ({1'b0, wr_row} < ROWS_EXT);

  // The write targets the pre-edge back bank, so a write coinciding with a
  // swap lands in the bank that becomes the front.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      front <= 1'b0;
      for (int b = 0; b < 2; b++) begin
        for (int r = 0; r < ROWS; r++) begin
          mem[b][r] <= '0;
        end
      end
    end else begin
      if (toggle) begin
        front <= ~front;
      end
      if (wr_ok) begin
        mem[back][wr_row] <= '{red: wr_red, green: wr_green};
      end
    end
  end

  assign rd_red   = mem[front][rd_row].red;
  assign rd_green = mem[front][rd_row].green;

endmodule

// File: rtl/dz_scan_ctrl.sv
// dz_scan_ctrl: row-scan driver for a ROWS x COLS bicolour LED dot matrix.
//   clk, rst : clock, async active-high reset
//   bus      : dz_scan_ctrl_if slave (enable, write port, swap handshake,
//              blink, frame_start and the row/column pins)
// Each row gets a DIV-clock slot whose first DEAD clocks have columns blanked.
// Bank swaps and blink-phase changes only happen at the wrap from the last
// row back to row 0, so the display never tears. All pins are registered and
// lag the scan counters by one clock.
module dz_scan_ctrl
  import dz_pkg::*;
#(
  parameter int ROWS     = 8,
  parameter int COLS     = 8,
  parameter int DIV      = 50000,
  parameter int DEAD     = 4,
  parameter int BLINK_FR = 64
) (
  input logic           clk,
  input logic           rst,
  dz_scan_ctrl_if.slave bus
);

  localparam int RW = row_w(ROWS);
  localparam int DW = cnt_w(DIV);
  localparam int FW = cnt_w(BLINK_FR);

  localparam logic [ROWS-1:0] ROW0_HOT = ROWS'(1);

  logic [DW-1:0]   div_cnt;
  logic [RW-1:0]   row_idx;
  logic [FW-1:0]   frame_cnt;
  blink_ph_e       phase;
  logic            slot_end;
  logic            wrap;
  logic            toggle;
  logic [COLS-1:0] rd_red;
  logic [COLS-1:0] rd_green;

  assign slot_end = bus.en && (div_cnt == DW'(DIV - 1));
  assign wrap     = slot_end && (row_idx == RW'(ROWS - 1));
  assign toggle   = wrap && bus.swap_pend;

  dz_frame_buf #(
    .ROWS (ROWS),
    .COLS (COLS),
    .RW   (RW)
  ) u_frame_buf (
    .clk      (clk),
    .rst      (rst),
    .wr_en    (bus.wr_en),
    .wr_row   (bus.wr_row),
    .wr_red   (bus.wr_red),
    .wr_green (bus.wr_green),
    .toggle   (toggle),
    .rd_row   (row_idx),
    .rd_red   (rd_red),
    .rd_green (rd_green)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      div_cnt         <= '0;
      row_idx         <= '0;
      frame_cnt       <= '0;
      phase           <= PH_VISIBLE;
      bus.swap_pend   <= 1'b0;
      bus.frame_start <= 1'b0;
      bus.row_n       <= '1;
      bus.col_r       <= '0;
      bus.col_g       <= '0;
    end else begin
      // A request arriving on the completing edge is dropped: pend is still
      // high there, and a second swap would need a fresh request.
      if (toggle) begin
        bus.swap_pend <= 1'b0;
      end else if (bus.swap_req) begin
        bus.swap_pend <= 1'b1;
      end

      if (!bus.en) begin
        div_cnt         <= '0;
        row_idx         <= '0;
        frame_cnt       <= '0;
        phase           <= PH_VISIBLE;
        bus.frame_start <= 1'b0;
        bus.row_n       <= '1;
        bus.col_r       <= '0;
        bus.col_g       <= '0;
      end else begin
        if (slot_end) begin
          div_cnt <= '0;
          row_idx <= wrap ? '0 : row_idx + RW'(1);
        end else begin
          div_cnt <= div_cnt + DW'(1);
        end

        if (!bus.blink) begin
          frame_cnt <= '0;
          phase     <= PH_VISIBLE;
        end else if (wrap) begin
          if (frame_cnt == FW'(BLINK_FR - 1)) begin
            frame_cnt <= '0;
            phase     <= (phase == PH_VISIBLE) ? PH_OFF : PH_VISIBLE;
          end else begin
            frame_cnt <= frame_cnt + FW'(1);
          end
        end

        bus.row_n       <= ~(ROW0_HOT << row_idx);
        bus.frame_start <= (row_idx == '0) && (div_cnt == '0);
        if ((div_cnt < DW'(DEAD)) || (phase == PH_OFF)) begin
          bus.col_r <= '0;
          bus.col_g <= '0;
        end else begin
          bus.col_r <= rd_red;
          bus.col_g <= rd_green;
        end
      end
    end
  end

endmodule

// File: tb/tb_dz_scan_ctrl.sv
// Directed bench for dz_scan_ctrl with ROWS=8, COLS=8, DIV=4, DEAD=1,
// BLINK_FR=2: one frame is 32 clocks, each row slot 4 clocks, the first clock
// of every slot dark. Inputs are driven and outputs sampled on the falling
// edge. With ROWS=8 every 3-bit wr_row value is a real row, so the
// out-of-range write case cannot be expressed at this size.
module tb_dz_scan_ctrl;

  logic clk = 1'b0;
  logic rst;
  int   checks   = 0;
  int   failures = 0;
  logic pend_first;
  logic pend_mid;
  logic pend_end;

  dz_scan_ctrl_if #(.ROWS(8), .COLS(8)) bus ();

  dz_scan_ctrl #(
    .ROWS     (8),
    .COLS     (8),
    .DIV      (4),
    .DEAD     (1),
    .BLINK_FR (2)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached, checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  // Runs one full frame starting at row 0. Expected columns: rows 3 and 5
  // carry the given data on clocks 2-4 of their slot when vis=1, everything
  // else dark. Optionally pulses swap_req or a write on a given frame clock.
  task automatic run_frame(input string tag,
                           input logic [7:0] r3r, input logic [7:0] r3g,
                           input logic [7:0] r5r, input logic [7:0] r5g,
                           input bit vis, input int req_off, input int wr_off,
                           input logic [2:0] wrow, input logic [7:0] wred,
                           input logic [7:0] wgrn);
    for (int o = 0; o < 32; o++) begin
      int         r;
      int         d;
      logic [7:0] er;
      logic [7:0] eg;
      logic [7:0] erow;
      logic       efs;
      bus.swap_req = (o == req_off);
      bus.wr_en    = (o == wr_off);
      bus.wr_row   = wrow;
      bus.wr_red   = wred;
      bus.wr_green = wgrn;
      @(negedge clk);
      bus.swap_req = 1'b0;
      bus.wr_en    = 1'b0;
      r    = o / 4;
      d    = o % 4;
      erow = 8'h01 << r;
      erow = ~erow;
      efs  = (o == 0);
      er   = 8'h00;
      eg   = 8'h00;
      if (vis && d != 0) begin
        if (r == 3) begin
          er = r3r;
          eg = r3g;
        end else if (r == 5) begin
          er = r5r;
          eg = r5g;
        end
      end
      if (o == 0)  pend_first = bus.swap_pend;
      if (o == 30) pend_mid   = bus.swap_pend;
      if (o == 31) pend_end   = bus.swap_pend;
      checks++;
      if (bus.row_n !== erow) begin
        failures++;
        $display("FAIL %s row_n clk=%0d got=%h exp=%h", tag, o, bus.row_n, erow);
      end
      checks++;
      if (bus.frame_start !== efs) begin
        failures++;
        $display("FAIL %s frame_start clk=%0d got=%b exp=%b", tag, o, bus.frame_start, efs);
      end
      checks++;
      if (bus.col_r !== er) begin
        failures++;
        $display("FAIL %s col_r clk=%0d got=%h exp=%h", tag, o, bus.col_r, er);
      end
      checks++;
      if (bus.col_g !== eg) begin
        failures++;
        $display("FAIL %s col_g clk=%0d got=%h exp=%h", tag, o, bus.col_g, eg);
      end
    end
  endtask

  task automatic test_reset();
    rst          = 1'b1;
    bus.en       = 1'b0;
    bus.wr_en    = 1'b0;
    bus.wr_row   = 3'd0;
    bus.wr_red   = 8'h00;
    bus.wr_green = 8'h00;
    bus.swap_req = 1'b0;
    bus.blink    = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if (bus.row_n !== 8'hFF) begin
      failures++;
      $display("FAIL reset row_n got=%h exp=ff", bus.row_n);
    end
    checks++;
    if (bus.col_r !== 8'h00 || bus.col_g !== 8'h00) begin
      failures++;
      $display("FAIL reset cols got=%h/%h exp=00/00", bus.col_r, bus.col_g);
    end
    checks++;
    if (bus.swap_pend !== 1'b0 || bus.frame_start !== 1'b0) begin
      failures++;
      $display("FAIL reset pend/fs got=%b/%b exp=0/0", bus.swap_pend, bus.frame_start);
    end
    rst = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if (bus.row_n !== 8'hFF || bus.frame_start !== 1'b0) begin
      failures++;
      $display("FAIL idle_dark row_n/fs got=%h/%b exp=ff/0", bus.row_n, bus.frame_start);
    end
  endtask

  task automatic test_scan();
    bus.en = 1'b1;
    run_frame("scan_f0", 8'h00, 8'h00, 8'h00, 8'h00, 1'b1, -1, -1, 3'd0, 8'h00, 8'h00);
    run_frame("scan_f1", 8'h00, 8'h00, 8'h00, 8'h00, 1'b1, -1, -1, 3'd0, 8'h00, 8'h00);
    checks++;
    if (pend_end !== 1'b0) begin
      failures++;
      $display("FAIL scan swap_pend got=%b exp=0", pend_end);
    end
  endtask

  task automatic test_write_swap();
    // Write to back bank only: display stays dark.
    run_frame("wr_noswap", 8'h00, 8'h00, 8'h00, 8'h00, 1'b1, -1, 0, 3'd3, 8'h3C, 8'h18);
    // Request mid-frame: pending until the wrap edge closing this frame.
    run_frame("swap_wait", 8'h00, 8'h00, 8'h00, 8'h00, 1'b1, 0, -1, 3'd0, 8'h00, 8'h00);
    checks++;
    if (pend_first !== 1'b1 || pend_mid !== 1'b1 || pend_end !== 1'b0) begin
      failures++;
      $display("FAIL swap_pend_window got=%b%b%b exp=110", pend_first, pend_mid, pend_end);
    end
    // New front shows row 3; a request on the wrap edge only sets pend.
    run_frame("swap_shown", 8'h3C, 8'h18, 8'h00, 8'h00, 1'b1, 31, -1, 3'd0, 8'h00, 8'h00);
    checks++;
    if (pend_mid !== 1'b0 || pend_end !== 1'b1) begin
      failures++;
      $display("FAIL req_on_wrap pend mid/end got=%b/%b exp=0/1", pend_mid, pend_end);
    end
  endtask

  task automatic test_back_to_back();
    // Still the old front for this frame; a second request while pending
    // must not add a second toggle.
    run_frame("pend_frame", 8'h3C, 8'h18, 8'h00, 8'h00, 1'b1, 10, -1, 3'd0, 8'h00, 8'h00);
    checks++;
    if (pend_first !== 1'b1 || pend_mid !== 1'b1 || pend_end !== 1'b0) begin
      failures++;
      $display("FAIL double_req pend got=%b%b%b exp=110", pend_first, pend_mid, pend_end);
    end
    // Front is now the untouched bank (all zero). Queue another swap and
    // write row 5 on the very wrap edge that performs it.
    run_frame("old_front", 8'h00, 8'h00, 8'h00, 8'h00, 1'b1, 5, 31, 3'd5, 8'hA5, 8'h5A);
    checks++;
    if (pend_mid !== 1'b1 || pend_end !== 1'b0) begin
      failures++;
      $display("FAIL swap2 pend mid/end got=%b/%b exp=1/0", pend_mid, pend_end);
    end
    run_frame("wr_on_swap", 8'h3C, 8'h18, 8'hA5, 8'h5A, 1'b1, -1, -1, 3'd0, 8'h00, 8'h00);
  endtask

  task automatic test_blink();
    bus.blink = 1'b1;
    run_frame("blink_f0", 8'h3C, 8'h18, 8'hA5, 8'h5A, 1'b1, -1, -1, 3'd0, 8'h00, 8'h00);
    run_frame("blink_f1", 8'h3C, 8'h18, 8'hA5, 8'h5A, 1'b1, -1, -1, 3'd0, 8'h00, 8'h00);
    run_frame("blink_f2", 8'h3C, 8'h18, 8'hA5, 8'h5A, 1'b0, -1, -1, 3'd0, 8'h00, 8'h00);
    run_frame("blink_f3", 8'h3C, 8'h18, 8'hA5, 8'h5A, 1'b0, -1, -1, 3'd0, 8'h00, 8'h00);
    run_frame("blink_f4", 8'h3C, 8'h18, 8'hA5, 8'h5A, 1'b1, -1, -1, 3'd0, 8'h00, 8'h00);
    run_frame("blink_f5", 8'h3C, 8'h18, 8'hA5, 8'h5A, 1'b1, -1, -1, 3'd0, 8'h00, 8'h00);
    run_frame("blink_f6", 8'h3C, 8'h18, 8'hA5, 8'h5A, 1'b0, -1, -1, 3'd0, 8'h00, 8'h00);
    // Dropping blink during an off phase makes the very next frame visible.
    bus.blink = 1'b0;
    run_frame("blink_off", 8'h3C, 8'h18, 8'hA5, 8'h5A, 1'b1, -1, -1, 3'd0, 8'h00, 8'h00);
  endtask

  task automatic test_enable();
    for (int i = 0; i < 22; i++) begin
      bus.swap_req = (i == 0);
      @(negedge clk);
    end
    bus.swap_req = 1'b0;
    // Now in row 5, second clock of the slot.
    checks++;
    if (bus.row_n !== 8'hDF || bus.col_r !== 8'hA5 || bus.col_g !== 8'h5A) begin
      failures++;
      $display("FAIL mid_row5 row_n/r/g got=%h/%h/%h exp=df/a5/5a", bus.row_n, bus.col_r, bus.col_g);
    end
    checks++;
    if (bus.swap_pend !== 1'b1) begin
      failures++;
      $display("FAIL mid_row5 swap_pend got=%b exp=1", bus.swap_pend);
    end
    bus.en = 1'b0;
    @(negedge clk);
    checks++;
    if (bus.row_n !== 8'hFF || bus.col_r !== 8'h00 || bus.col_g !== 8'h00 ||
        bus.frame_start !== 1'b0) begin
      failures++;
      $display("FAIL en_drop row_n/r/g/fs got=%h/%h/%h/%b exp=ff/00/00/0",
               bus.row_n, bus.col_r, bus.col_g, bus.frame_start);
    end
    repeat (40) @(negedge clk);
    checks++;
    if (bus.row_n !== 8'hFF || bus.swap_pend !== 1'b1) begin
      failures++;
      $display("FAIL disabled row_n/pend got=%h/%b exp=ff/1", bus.row_n, bus.swap_pend);
    end
    // Restart at row 0 with frame_start, same front; the pending swap then
    // completes at the end of this frame.
    bus.en = 1'b1;
    run_frame("en_restart", 8'h3C, 8'h18, 8'hA5, 8'h5A, 1'b1, -1, -1, 3'd0, 8'h00, 8'h00);
    checks++;
    if (pend_first !== 1'b1 || pend_end !== 1'b0) begin
      failures++;
      $display("FAIL en_restart pend first/end got=%b/%b exp=1/0", pend_first, pend_end);
    end
    run_frame("after_en_swap", 8'h00, 8'h00, 8'h00, 8'h00, 1'b1, -1, -1, 3'd0, 8'h00, 8'h00);
  endtask

  task automatic test_rst_mid();
    for (int i = 0; i < 10; i++) begin
      bus.swap_req = (i == 0);
      @(negedge clk);
    end
    bus.swap_req = 1'b0;
    checks++;
    if (bus.row_n !== 8'hFB || bus.swap_pend !== 1'b1) begin
      failures++;
      $display("FAIL pre_rst row_n/pend got=%h/%b exp=fb/1", bus.row_n, bus.swap_pend);
    end
    #2;
    rst = 1'b1;
    #1;
    checks++;
    if (bus.row_n !== 8'hFF || bus.swap_pend !== 1'b0 || bus.frame_start !== 1'b0) begin
      failures++;
      $display("FAIL async_rst row_n/pend/fs got=%h/%b/%b exp=ff/0/0",
               bus.row_n, bus.swap_pend, bus.frame_start);
    end
    @(negedge clk);
    rst = 1'b0;
    // The bank that held rows 3 and 5 must have been cleared by reset.
    run_frame("rst_f0", 8'h00, 8'h00, 8'h00, 8'h00, 1'b1, 0, -1, 3'd0, 8'h00, 8'h00);
    checks++;
    if (pend_first !== 1'b1 || pend_end !== 1'b0) begin
      failures++;
      $display("FAIL rst_swap pend first/end got=%b/%b exp=1/0", pend_first, pend_end);
    end
    run_frame("rst_cleared", 8'h00, 8'h00, 8'h00, 8'h00, 1'b1, -1, -1, 3'd0, 8'h00, 8'h00);
  endtask

  initial begin
    test_reset();
    test_scan();
    test_write_swap();
    test_back_to_back();
    test_blink();
    test_enable();
    test_rst_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
